// File: rtl/aes_arb_pkg.sv
// Shared constants for the two-master AES Wishbone arbiter.
package aes_arb_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUSY   = 2'd1;
    localparam logic [1:0] ST_TO_ACK = 2'd2;

    localparam logic [31:0] TIMEOUT_DATA_DEF = 32'hDEAD_BEEF;

    localparam int unsigned M0 = 0;
    localparam int unsigned M1 = 1;

endpackage

// File: rtl/arb_rr_pick2.sv
// Combinational 2-way round-robin picker; on a tie the master that did not own last wins.
module arb_rr_pick2
    import aes_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic [1:0] pick,
    output logic       valid
);

    always_comb begin
        pick      = '0;
        pick[M0]  = req[M0] & (~req[M1] | last_owner);
        pick[M1]  = req[M1] & (~req[M0] | ~last_owner);
        valid     = |req;
    end

endmodule

// File: rtl/aes_bus_arbiter.sv
// Two-master Wishbone arbiter in front of the AES core: round-robin grant,
// cyc-held bus lock and an ack watchdog that self-acks a hung access.
module aes_bus_arbiter
    import aes_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned CNT_W          = 9,
    parameter logic [31:0] TIMEOUT_DATA   = TIMEOUT_DATA_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_cyc,
    input  logic        m0_stb,
    input  logic        m0_we,
    input  logic [3:0]  m0_sel,
    input  logic [27:0] m0_adr,
    input  logic [31:0] m0_dat_w,
    output logic        m0_ack,
    output logic [31:0] m0_dat_r,
    input  logic        m1_cyc,
    input  logic        m1_stb,
    input  logic        m1_we,
    input  logic [3:0]  m1_sel,
    input  logic [27:0] m1_adr,
    input  logic [31:0] m1_dat_w,
    output logic        m1_ack,
    output logic [31:0] m1_dat_r,
    output logic        s_cyc,
    output logic        s_stb,
    output logic        s_we,
    output logic [3:0]  s_sel,
    output logic [27:0] s_adr,
    output logic [31:0] s_dat_w,
    input  logic        s_ack,
    input  logic [31:0] s_dat_r,
    output logic [1:0]  grant,
    output logic        timeout_flag,
    input  logic        timeout_clr
);

    logic [1:0]       state;
    logic [1:0]       grant_q;
    logic             last_owner;
    logic [CNT_W-1:0] cnt;

    logic [1:0]  req;
    logic [1:0]  pick;
    logic        pick_valid;
    logic        own_m1;
    logic        own_cyc, own_stb, own_we;
    logic [3:0]  own_sel;
    logic [27:0] own_adr;
    logic [31:0] own_dat_w;

    assign req[M0] = m0_cyc & m0_stb;
    assign req[M1] = m1_cyc & m1_stb;

    arb_rr_pick2 u_pick (
        .req        (req),
        .last_owner (last_owner),
        .pick       (pick),
        .valid      (pick_valid)
    );

    assign own_m1    = grant_q[M1];
    assign own_cyc   = own_m1 ? m1_cyc   : m0_cyc;
    assign own_stb   = own_m1 ? m1_stb   : m0_stb;
    assign own_we    = own_m1 ? m1_we    : m0_we;
    assign own_sel   = own_m1 ? m1_sel   : m0_sel;
    assign own_adr   = own_m1 ? m1_adr   : m0_adr;
    assign own_dat_w = own_m1 ? m1_dat_w : m0_dat_w;
    assign grant     = grant_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            grant_q      <= '0;
            last_owner   <= 1'b1;
            cnt          <= '0;
            timeout_flag <= 1'b0;
        end else begin
            // TO_ACK sets the flag at its closing edge, so a coincident clear loses.
            if (state == ST_TO_ACK)
                timeout_flag <= 1'b1;
            else if (timeout_clr)
                timeout_flag <= 1'b0;

            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (pick_valid) begin
                        grant_q <= pick;
                        state   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!own_cyc) begin
                        state      <= ST_IDLE;
                        last_owner <= own_m1;
                        grant_q    <= '0;
                        cnt        <= '0;
                    end else if (own_stb && !s_ack) begin
                        if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                            state <= ST_TO_ACK;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else begin
                        cnt <= '0;
                    end
                end
                ST_TO_ACK: begin
                    cnt <= '0;
                    if (own_cyc) begin
                        state <= ST_BUSY;
                    end else begin
                        state      <= ST_IDLE;
                        last_owner <= own_m1;
                        grant_q    <= '0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    grant_q <= '0;
                    cnt     <= '0;
                end
            endcase
        end
    end

    always_comb begin
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_sel    = '0;
        s_adr    = '0;
        s_dat_w  = '0;
        m0_ack   = 1'b0;
        m0_dat_r = '0;
        m1_ack   = 1'b0;
        m1_dat_r = '0;
        case (state)
            ST_BUSY: begin
                s_cyc   = own_cyc;
                s_stb   = own_stb;
                s_we    = own_we;
                s_sel   = own_sel;
                s_adr   = own_adr;
                s_dat_w = own_dat_w;
                // Gating with cyc keeps an aborted access from seeing a late ack.
                if (own_m1) begin
                    m1_ack   = s_ack & own_cyc & own_stb;
                    m1_dat_r = s_dat_r;
                end else begin
                    m0_ack   = s_ack & own_cyc & own_stb;
                    m0_dat_r = s_dat_r;
                end
            end
            ST_TO_ACK: begin
                if (own_m1) begin
                    m1_ack   = 1'b1;
                    m1_dat_r = TIMEOUT_DATA;
                end else begin
                    m0_ack   = 1'b1;
                    m0_dat_r = TIMEOUT_DATA;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_aes_bus_arbiter.sv
// Directed bench for aes_bus_arbiter with an 8-cycle watchdog.
module tb_aes_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_cyc, m0_stb, m0_we;
    logic [3:0]  m0_sel;
    logic [27:0] m0_adr;
    logic [31:0] m0_dat_w;
    logic        m0_ack;
    logic [31:0] m0_dat_r;
    logic        m1_cyc, m1_stb, m1_we;
    logic [3:0]  m1_sel;
    logic [27:0] m1_adr;
    logic [31:0] m1_dat_w;
    logic        m1_ack;
    logic [31:0] m1_dat_r;
    logic        s_cyc, s_stb, s_we;
    logic [3:0]  s_sel;
    logic [27:0] s_adr;
    logic [31:0] s_dat_w;
    logic        s_ack;
    logic [31:0] s_dat_r;
    logic [1:0]  grant;
    logic        timeout_flag;
    logic        timeout_clr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_bus_arbiter #(
        .TIMEOUT_CYCLES (8),
        .CNT_W          (4),
        .TIMEOUT_DATA   (32'hDEAD_BEEF)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .m0_cyc       (m0_cyc),
        .m0_stb       (m0_stb),
        .m0_we        (m0_we),
        .m0_sel       (m0_sel),
        .m0_adr       (m0_adr),
        .m0_dat_w     (m0_dat_w),
        .m0_ack       (m0_ack),
        .m0_dat_r     (m0_dat_r),
        .m1_cyc       (m1_cyc),
        .m1_stb       (m1_stb),
        .m1_we        (m1_we),
        .m1_sel       (m1_sel),
        .m1_adr       (m1_adr),
        .m1_dat_w     (m1_dat_w),
        .m1_ack       (m1_ack),
        .m1_dat_r     (m1_dat_r),
        .s_cyc        (s_cyc),
        .s_stb        (s_stb),
        .s_we         (s_we),
        .s_sel        (s_sel),
        .s_adr        (s_adr),
        .s_dat_w      (s_dat_w),
        .s_ack        (s_ack),
        .s_dat_r      (s_dat_r),
        .grant        (grant),
        .timeout_flag (timeout_flag),
        .timeout_clr  (timeout_clr)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_sel = 4'h0; m0_adr = '0; m0_dat_w = '0;
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_sel = 4'h0; m1_adr = '0; m1_dat_w = '0;
        s_ack = 1'b0; s_dat_r = '0; timeout_clr = 1'b0;
        tick();
        tick();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_s_cyc", 32'(s_cyc), 32'd0);
        chk("rst_m0_ack", 32'(m0_ack), 32'd0);
        chk("rst_m1_ack", 32'(m1_ack), 32'd0);
        chk("rst_m0_dat_r", m0_dat_r, 32'd0);
        chk("rst_flag", 32'(timeout_flag), 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: single m0 read, acked on the third BUSY cycle
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_sel = 4'hF; m0_adr = 28'h000_0010;
        #1;
        chk("t1_idle_s_cyc", 32'(s_cyc), 32'd0);
        tick();
        chk("t1_grant", 32'(grant), 32'd1);
        chk("t1_s_cyc", 32'(s_cyc), 32'd1);
        chk("t1_s_stb", 32'(s_stb), 32'd1);
        chk("t1_s_adr", 32'(s_adr), 32'h10);
        chk("t1_s_sel", 32'(s_sel), 32'hF);
        chk("t1_no_ack_yet", 32'(m0_ack), 32'd0);
        tick();
        tick();
        s_ack = 1'b1; s_dat_r = 32'h1234_5678;
        #1;
        chk("t1_m0_ack", 32'(m0_ack), 32'd1);
        chk("t1_m0_dat_r", m0_dat_r, 32'h1234_5678);
        chk("t1_m1_ack", 32'(m1_ack), 32'd0);
        chk("t1_m1_dat_r", m1_dat_r, 32'd0);
        tick();
        s_ack = 1'b0; s_dat_r = '0; m0_cyc = 1'b0; m0_stb = 1'b0;
        #1;
        chk("t1_ack_drop", 32'(m0_ack), 32'd0);
        chk("t1_s_cyc_drop", 32'(s_cyc), 32'd0);
        tick();
        chk("t1_release", 32'(grant), 32'd0);

        // 2: tie after reset goes to m0, next tie to m1 after a bubble
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m0_cyc = 1'b1; m0_stb = 1'b1;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 28'h0AB_CDEF;
        #1;
        chk("t2_idle_grant", 32'(grant), 32'd0);
        tick();
        chk("t2_first_m0", 32'(grant), 32'd1);
        chk("t2_s_adr_m0", 32'(s_adr), 32'h10);
        m0_cyc = 1'b0; m0_stb = 1'b0;
        tick();
        chk("t2_bubble", 32'(grant), 32'd0);
        chk("t2_bubble_s_cyc", 32'(s_cyc), 32'd0);
        m0_cyc = 1'b1; m0_stb = 1'b1;
        tick();
        chk("t2_second_m1", 32'(grant), 32'd2);
        chk("t2_s_adr_m1", 32'(s_adr), 32'h0AB_CDEF);
        s_ack = 1'b1;
        #1;
        chk("t2_m1_ack", 32'(m1_ack), 32'd1);
        chk("t2_m0_stalled", 32'(m0_ack), 32'd0);
        s_ack = 1'b0;
        m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        tick();
        tick();

        // 3: m0 holds the bus for four writes while m1 waits
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1;
        m1_cyc = 1'b1; m1_stb = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            m0_adr = 28'h100 + 28'(i);
            m0_dat_w = 32'hA000_0000 + 32'(i);
            s_ack = 1'b1;
            #1;
            chk("t3_lock_grant", 32'(grant), 32'd1);
            chk("t3_s_dat_w", s_dat_w, 32'hA000_0000 + 32'(i));
            chk("t3_s_we", 32'(s_we), 32'd1);
            chk("t3_m0_ack", 32'(m0_ack), 32'd1);
            chk("t3_m1_ack", 32'(m1_ack), 32'd0);
            tick();
        end
        s_ack = 1'b0;
        m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0;
        #1;
        chk("t3_s_cyc_drop", 32'(s_cyc), 32'd0);
        tick();
        chk("t3_bubble", 32'(grant), 32'd0);
        tick();
        chk("t3_m1_after", 32'(grant), 32'd2);
        m1_cyc = 1'b0; m1_stb = 1'b0;
        tick();

        // 4: hung slave, watchdog self-acks on the ninth stb cycle
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 28'h20;
        tick();
        repeat (7) tick();
        chk("t4_cyc8_ack", 32'(m0_ack), 32'd0);
        chk("t4_cyc8_s_stb", 32'(s_stb), 32'd1);
        tick();
        chk("t4_to_ack", 32'(m0_ack), 32'd1);
        chk("t4_to_data", m0_dat_r, 32'hDEAD_BEEF);
        chk("t4_to_s_stb", 32'(s_stb), 32'd0);
        chk("t4_to_s_cyc", 32'(s_cyc), 32'd0);
        chk("t4_to_m1_ack", 32'(m1_ack), 32'd0);
        chk("t4_flag_pending", 32'(timeout_flag), 32'd0);
        m0_cyc = 1'b0; m0_stb = 1'b0;
        tick();
        chk("t4_flag_set", 32'(timeout_flag), 32'd1);
        chk("t4_idle", 32'(grant), 32'd0);
        tick();
        chk("t4_flag_sticky", 32'(timeout_flag), 32'd1);
        timeout_clr = 1'b1;
        tick();
        timeout_clr = 1'b0;
        chk("t4_flag_cleared", 32'(timeout_flag), 32'd0);

        // 5: clear coincident with TO_ACK loses; owner keeps bus after TO_ACK
        m0_cyc = 1'b1; m0_stb = 1'b1;
        tick();
        repeat (8) tick();
        chk("t5_to_ack", 32'(m0_ack), 32'd1);
        timeout_clr = 1'b1;
        m0_stb = 1'b0;
        tick();
        timeout_clr = 1'b0;
        #1;
        chk("t5_set_wins", 32'(timeout_flag), 32'd1);
        chk("t5_still_owner", 32'(grant), 32'd1);
        chk("t5_s_cyc", 32'(s_cyc), 32'd1);
        chk("t5_s_stb", 32'(s_stb), 32'd0);
        s_ack = 1'b1;
        #1;
        chk("t5_ack_ignored", 32'(m0_ack), 32'd0);
        s_ack = 1'b0;
        m0_cyc = 1'b0;
        tick();
        timeout_clr = 1'b1;
        tick();
        timeout_clr = 1'b0;

        // 6: reset mid-access with m1 owner, then tie goes to m0
        m1_cyc = 1'b1; m1_stb = 1'b1;
        tick();
        chk("t6_m1_owner", 32'(grant), 32'd2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("t6_rst_grant", 32'(grant), 32'd0);
        chk("t6_rst_s_cyc", 32'(s_cyc), 32'd0);
        chk("t6_rst_m1_ack", 32'(m1_ack), 32'd0);
        chk("t6_rst_flag", 32'(timeout_flag), 32'd0);
        m0_cyc = 1'b1; m0_stb = 1'b1;
        tick();
        chk("t6_tie_m0", 32'(grant), 32'd1);
        m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
